// File: rtl/mma_pkg.sv
// Shared types and width helpers for the matmul tile accumulator.
//   mma_state_e : tile FSM state (IDLE waits for the first beat of a tile, ACCUM inside one)
//   beat_cnt_w  : width of a beat counter that must represent 0..max_beats
//   dot_w       : exact width of a K-term sum of signed PxP products
package mma_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACCUM
  } mma_state_e;

  function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

  function automatic int unsigned dot_w(input int unsigned p, input int unsigned k);
    return 2 * p + $clog2(k);
  endfunction

endpackage

// File: rtl/mma_dot_product.sv
// Combinational signed dot product of two K-element vectors.
// Ports:
//   a_i   : K signed P-bit operands (one row of A)
//   b_i   : K signed P-bit operands (one column of B)
//   dot_o : exact signed sum of the K products, OutW bits wide
// The products are summed in a balanced binary tree; the tree is padded to a power of two
// with zero leaves so any K works.
module mma_dot_product #(
  parameter int unsigned K    = 4,
  parameter int unsigned P    = 8,
  parameter int unsigned OutW = 2 * P + 2
) (
  input  logic [K-1:0][P-1:0]   a_i,
  input  logic [K-1:0][P-1:0]   b_i,
  output logic signed [OutW-1:0] dot_o
);

  localparam int unsigned Lvl    = $clog2(K);
  localparam int unsigned Leaves = 1 << Lvl;

  // Heap layout: node 0 is the root, leaves start at Leaves-1.
  logic signed [OutW-1:0] node [2*Leaves-1];

  for (genvar k = 0; k < Leaves; k++) begin : g_leaf
    if (k < K) begin : g_prod
      logic signed [2*P-1:0] prod;
      assign prod = $signed(a_i[k]) * $signed(b_i[k]);
      assign node[Leaves-1+k] = OutW'(prod);
    end else begin : g_pad
      assign node[Leaves-1+k] = '0;
    end
  end

  for (genvar n = 0; n < Leaves - 1; n++) begin : g_add
    assign node[n] = node[2*n+1] + node[2*n+2];
  end

  assign dot_o = node[0];

endmodule

// File: rtl/matmul_tile_accumulator.sv
// Streaming matrix-multiply tile accumulator: D = C + sum over beats of A*B.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   A [M][K], B [K][N]    : signed P-bit operands of one beat
//   C [M][N]              : tile initial value, used only on the first beat of a tile
//   valid_in/ready_in     : beat handshake; last_in marks the final beat of a tile
//   D, valid_out/ready_out: completed tile result and its handshake
//   beats_out             : number of beats in the tile held in D (saturates at MAX_BEATS)
//   err_o                 : sticky error (beat count overflow, or saturation when enabled)
// Build option: define MMA_ACC_SATURATE_EN to clamp accumulator updates instead of wrapping.
module matmul_tile_accumulator
  import mma_pkg::*;
#(
  parameter int unsigned M         = 4,
  parameter int unsigned N         = 4,
  parameter int unsigned K         = 4,
  parameter int unsigned P         = 8,
  parameter int unsigned ACC_W     = 4 * P,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned BeatW    = beat_cnt_w(MAX_BEATS)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [M-1:0][K-1:0][P-1:0]       A,
  input  logic [K-1:0][N-1:0][P-1:0]       B,
  input  logic [M-1:0][N-1:0][ACC_W-1:0]   C,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic                             last_in,
  output logic [M-1:0][N-1:0][ACC_W-1:0]   D,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [BeatW-1:0]                 beats_out,
  output logic                             err_o
);

  localparam int unsigned DotW = dot_w(P, K);
  localparam logic [BeatW-1:0] MaxCnt = BeatW'(MAX_BEATS);

  mma_state_e                          state_q, state_d;
  logic [M-1:0][N-1:0][ACC_W-1:0]      acc_q, acc_d;
  logic [M-1:0][N-1:0][ACC_W-1:0]      d_q, d_d;
  logic [BeatW-1:0]                    cnt_q, cnt_d;
  logic [BeatW-1:0]                    beats_q, beats_d;
  logic                                vout_q, vout_d;
  logic                                err_q, err_d;

  logic [M-1:0][N-1:0][ACC_W-1:0]      acc_upd;
  logic [N-1:0][K-1:0][P-1:0]          b_col;
  logic                                accept;
  logic                                sat_any;
  logic [BeatW-1:0]                    cnt_nxt;
  logic                                cnt_ovf;

  // Only a last beat is blocked by a stalled output; partial sums keep flowing.
  assign ready_in = ~(vout_q & ~ready_out & last_in);
  assign accept   = valid_in & ready_in;

  for (genvar j = 0; j < N; j++) begin : g_bcol
    for (genvar k = 0; k < K; k++) begin : g_bk
      assign b_col[j][k] = B[k][j];
    end
  end

`ifdef MMA_ACC_SATURATE_EN
  localparam int unsigned SumW = ((ACC_W > DotW) ? ACC_W : DotW) + 1;
  logic [M*N-1:0] sat_hit;
  assign sat_any = |sat_hit;
`else
  assign sat_any = 1'b0;
`endif

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DotW-1:0]  dot;
      logic signed [ACC_W-1:0] base;

      mma_dot_product #(
        .K    (K),
        .P    (P),
        .OutW (DotW)
      ) u_dot (
        .a_i   (A[i]),
        .b_i   (b_col[j]),
        .dot_o (dot)
      );

      // The first beat of a tile starts from C, later beats from the running sum.
      assign base = (state_q == IDLE) ? $signed(C[i][j]) : $signed(acc_q[i][j]);

`ifdef MMA_ACC_SATURATE_EN
      logic signed [SumW-1:0] sum;
      logic                   ovf;
      assign sum = SumW'(base) + SumW'(dot);
      // Overflow when the bits above the ACC_W sign bit are not a pure sign extension.
      assign ovf = (sum[SumW-1:ACC_W-1] != {(SumW-ACC_W+1){sum[SumW-1]}});
      assign acc_upd[i][j] = ovf ? {sum[SumW-1], {(ACC_W-1){~sum[SumW-1]}}}
                                 : sum[ACC_W-1:0];
      assign sat_hit[i*N+j] = ovf;
`else
      assign acc_upd[i][j] = base + ACC_W'(dot);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    beats_d = beats_q;
    vout_d  = vout_q;
    err_d   = err_q;
    cnt_ovf = 1'b0;

    if (state_q == IDLE) begin
      cnt_nxt = BeatW'(1);
    end else if (cnt_q == MaxCnt) begin
      cnt_nxt = MaxCnt;
      cnt_ovf = 1'b1;
    end else begin
      cnt_nxt = cnt_q + BeatW'(1);
    end

    if (vout_q && ready_out) begin
      vout_d = 1'b0;
    end

    if (accept) begin
      acc_d = acc_upd;
      cnt_d = cnt_nxt;
      err_d = err_q | cnt_ovf | sat_any;
      if (last_in) begin
        state_d = IDLE;
        d_d     = acc_upd;
        beats_d = cnt_nxt;
        vout_d  = 1'b1;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      beats_q <= '0;
      vout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      beats_q <= beats_d;
      vout_q  <= vout_d;
      err_q   <= err_d;
    end
  end

  assign D         = d_q;
  assign beats_out = beats_q;
  assign valid_out = vout_q;
  assign err_o     = err_q;

endmodule
